bullet_pool_controller: RTL

Multi-slot projectile engine for the player ship. It replaces the single-bullet controller with a pool of `NUM_BULLETS` independent bullets, which share one reload timer and one movement divider. Hit feedback is per slot, and hit scoring saturates. It sits between the ship controller (fire, ship position) and the collision/render logic (per-slot positions, active mask, hit mask).

---
 rtl/bullet_pool_controller.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bullet_pool_controller.sv
// Pool of NUM_BULLETS independent projectiles sharing one reload timer and one movement divider.
// Optional macro BULLET_AUTOFIRE_EN: fire acts as a level trigger instead of a rising-edge trigger.
module bullet_pool_controller #(
  parameter int NUM_BULLETS   = 4,
  parameter int COORD_W       = 10,
  parameter int STEP_DIV      = 55000,
  parameter int RELOAD_DIV    = 50000,
  parameter int X_LIMIT       = 774,
  parameter int BULLET_STEP   = 1,
  parameter int SCORE_PER_HIT = 5,
  parameter int SCORE_W       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fire,
  input  logic [COORD_W-1:0]             ship_x,
  input  logic [COORD_W-1:0]             ship_y,
  input  logic [NUM_BULLETS-1:0]         hit_mask,
  output logic [NUM_BULLETS*COORD_W-1:0] bullet_x,
  output logic [NUM_BULLETS*COORD_W-1:0] bullet_y,
  output logic [NUM_BULLETS-1:0]         active_mask,
  output logic                           fire_ack,
  output logic [$clog2(NUM_BULLETS+1)-1:0] free_slots,
  output logic [SCORE_W-1:0]             scores
);

  localparam int CNT_W = $clog2(NUM_BULLETS+1);
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int RL_W  = (RELOAD_DIV > 0) ? $clog2(RELOAD_DIV+1) : 1;
  localparam int SUM_W = SCORE_W + 16;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(STEP_DIV-1);
  localparam logic [RL_W-1:0]    RL_MAX   = RL_W'(RELOAD_DIV);
  localparam logic [COORD_W-1:0] X_LIM_C  = COORD_W'(X_LIMIT);
  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(BULLET_STEP);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_FLYING,
    SLOT_HIT
  } slot_state_t;

  slot_state_t              state_q [NUM_BULLETS];
  slot_state_t              state_d [NUM_BULLETS];
  logic [COORD_W-1:0]       x_q [NUM_BULLETS];
  logic [COORD_W-1:0]       x_d [NUM_BULLETS];
  logic [COORD_W-1:0]       y_q [NUM_BULLETS];
  logic [COORD_W-1:0]       y_d [NUM_BULLETS];

  logic [DIV_W-1:0]         div_cnt;
  logic [RL_W-1:0]          reload_cnt;
  logic                     step_tick;
  logic                     ready;
  logic                     trigger;
  logic                     accept;
  logic                     any_idle;
  logic [NUM_BULLETS-1:0]   alloc_sel;
  logic [CNT_W-1:0]         hit_count;
  logic [CNT_W-1:0]         idle_count;
  logic [SUM_W-1:0]         score_sum;
  logic [SCORE_W-1:0]       score_d;
  logic                     fire_ack_q;
  logic [SCORE_W-1:0]       score_q;

  assign step_tick = (div_cnt == DIV_LAST);
  assign ready     = (reload_cnt == RL_MAX);

`ifdef BULLET_AUTOFIRE_EN
  assign trigger = fire;
`else
  logic fire_prev;

  always_ff @(posedge clk) begin
    if (reset) fire_prev <= 1'b0;
    else       fire_prev <= fire;
  end

  assign trigger = fire & ~fire_prev;
`endif

  assign accept = trigger & ready & any_idle;

  // Lowest-index IDLE slot wins allocation; HIT slots are not yet free.
  always_comb begin
    any_idle   = 1'b0;
    alloc_sel  = '0;
    idle_count = '0;
    hit_count  = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (state_q[i] == SLOT_IDLE) begin
        idle_count = idle_count + CNT_W'(1);
        if (!any_idle) begin
          alloc_sel[i] = 1'b1;
          any_idle     = 1'b1;
        end
      end
      if (state_q[i] == SLOT_HIT) hit_count = hit_count + CNT_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      case (state_q[i])
        SLOT_IDLE: begin
          if (accept && alloc_sel[i]) begin
            state_d[i] = SLOT_FLYING;
            x_d[i]     = ship_x;
            y_d[i]     = ship_y;
          end
        end
        SLOT_FLYING: begin
          if (hit_mask[i]) begin
            state_d[i] = SLOT_HIT;
          end else if (step_tick) begin
            if (x_q[i] >= X_LIM_C) state_d[i] = SLOT_IDLE;
            else                   x_d[i]     = x_q[i] + STEP_C;
          end
        end
        SLOT_HIT: state_d[i] = SLOT_IDLE;
        default:  state_d[i] = SLOT_IDLE;
      endcase
    end
  end

  // Score is wide-summed so any overflow past SCORE_W shows up as upper bits.
  always_comb begin
    score_sum = {{(SUM_W-SCORE_W){1'b0}}, score_q}
              + SUM_W'(SCORE_PER_HIT) * SUM_W'(hit_count);
    score_d   = (score_sum[SUM_W-1:SCORE_W] != '0) ? {SCORE_W{1'b1}}
                                                   : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        state_q[i] <= SLOT_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end
      div_cnt    <= '0;
      reload_cnt <= RL_MAX;
      fire_ack_q <= 1'b0;
      score_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
      end
      div_cnt <= step_tick ? '0 : div_cnt + DIV_W'(1);
      if (accept)           reload_cnt <= '0;
      else if (!ready)      reload_cnt <= reload_cnt + RL_W'(1);
      fire_ack_q <= accept;
      score_q    <= score_d;
    end
  end

  always_comb begin
    bullet_x    = '0;
    bullet_y    = '0;
    active_mask = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bullet_x[i*COORD_W +: COORD_W] = x_q[i];
      bullet_y[i*COORD_W +: COORD_W] = y_q[i];
      active_mask[i]                 = (state_q[i] == SLOT_FLYING);
    end
  end

  assign fire_ack   = fire_ack_q;
  assign free_slots = idle_count;
  assign scores     = score_q;

endmodule
